// File: rtl/blackjack_scoreboard.sv
// -----------------------------------------------------------------------------
// blackjack_scoreboard
//
// Sits between the blackjack game FSM and the board HEX/LED pins. It shows the
// player and dealer hand totals as two decimal digits each on active-low
// seven-segment displays. It keeps saturating win/loss tallies that count each
// round exactly once. It blinks a win or lose LED while a round result is held.
//
// Ports
//   clock         system clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   phand, dhand  player / dealer hand totals, unsigned 0..31
//   result        00 playing, 01 player lost, 11 player won, 10 treated as playing
//   clear_scores  synchronous active-high clear of both tallies
//   hex_p1/p0     player tens / units digit, active-low {g,f,e,d,c,b,a}
//   hex_d1/d0     dealer tens / units digit, same encoding
//   win_count     player wins tally (saturates at MAX_SCORE)
//   loss_count    player losses tally (saturates at MAX_SCORE)
//   led_win       blinks while a win is held
//   led_lose      blinks while a loss is held
// -----------------------------------------------------------------------------
module blackjack_scoreboard #(
   parameter int BLINK_DIV = 25000000,
   parameter int MAX_SCORE = 99
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [4:0] phand,
   input  logic [4:0] dhand,
   input  logic [1:0] result,
   input  logic       clear_scores,
   output logic [6:0] hex_p1,
   output logic [6:0] hex_p0,
   output logic [6:0] hex_d1,
   output logic [6:0] hex_d0,
   output logic [6:0] win_count,
   output logic [6:0] loss_count,
   output logic       led_win,
   output logic       led_lose
);

   localparam int              CNT_W     = $clog2(2 * BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(2 * BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_DIV);
   localparam logic [6:0]      SCORE_MAX = 7'(MAX_SCORE);
   localparam logic [6:0]      SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {WAIT, SHOW_WIN, SHOW_LOSE} state_t;

   // Active-low segment pattern for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

   // {tens[1:0], units[3:0]} of a 0..31 value using compares and one subtract.
   function automatic logic [5:0] split_bcd(input logic [4:0] v);
      if (v >= 5'd30)      return {2'd3, 4'(v - 5'd30)};
      else if (v >= 5'd20) return {2'd2, 4'(v - 5'd20)};
      else if (v >= 5'd10) return {2'd1, 4'(v - 5'd10)};
      else                 return {2'd0, v[3:0]};
   endfunction

   // Tens digit is blank for single-digit values.
   function automatic logic [6:0] tens_seg(input logic [1:0] t);
      return (t == 2'd0) ? SEG_BLANK : seg7({2'b00, t});
   endfunction

   // Saturating tally increment.
   function automatic logic [6:0] sat_inc(input logic [6:0] cnt, input logic en);
      return (en && (cnt != SCORE_MAX)) ? cnt + 7'd1 : cnt;
   endfunction

   logic [5:0]       p_bcd, d_bcd;
   logic [1:0]       res_p0;
   state_t           state_q, state_d;
   logic             win_ev, loss_ev;
   logic [CNT_W-1:0] blink_cnt;

   assign p_bcd = split_bcd(phand);
   assign d_bcd = split_bcd(dhand);

   // Stage p0: registered digits and registered round code.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hex_p1 <= SEG_BLANK;
         hex_p0 <= SEG_BLANK;
         hex_d1 <= SEG_BLANK;
         hex_d0 <= SEG_BLANK;
         res_p0 <= 2'b00;
      end else begin
         hex_p1 <= tens_seg(p_bcd[5:4]);
         hex_p0 <= seg7(p_bcd[3:0]);
         hex_d1 <= tens_seg(d_bcd[5:4]);
         hex_d0 <= seg7(d_bcd[3:0]);
         res_p0 <= result;
      end
   end

   // The state remembers the class of the previous code, so a round event is
   // only raised when leaving WAIT; a direct win<->lose flip is not a new round.
   always_comb begin
      state_d = state_q;
      win_ev  = 1'b0;
      loss_ev = 1'b0;
      case (state_q)
         WAIT: begin
            if (res_p0 == 2'b11) begin
               state_d = SHOW_WIN;
               win_ev  = 1'b1;
            end else if (res_p0 == 2'b01) begin
               state_d = SHOW_LOSE;
               loss_ev = 1'b1;
            end
         end
         SHOW_WIN: begin
            if (res_p0 == 2'b01)      state_d = SHOW_LOSE;
            else if (res_p0 != 2'b11) state_d = WAIT;
         end
         SHOW_LOSE: begin
            if (res_p0 == 2'b11)      state_d = SHOW_WIN;
            else if (res_p0 != 2'b01) state_d = WAIT;
         end
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= WAIT;
      else          state_q <= state_d;
   end

   // Stage p1: tallies, blink counter and LEDs, all driven by the state update.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         win_count  <= 7'd0;
         loss_count <= 7'd0;
      end else if (clear_scores) begin
         win_count  <= 7'd0;
         loss_count <= 7'd0;
      end else begin
         win_count  <= sat_inc(win_count, win_ev);
         loss_count <= sat_inc(loss_count, loss_ev);
      end
   end

   // LEDs are registered from the counter, so the lit LED appears one cycle
   // after state entry and drops on the same edge the state leaves.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         led_win   <= 1'b0;
         led_lose  <= 1'b0;
      end else if ((state_d != state_q) || (state_d == WAIT)) begin
         blink_cnt <= '0;
         led_win   <= 1'b0;
         led_lose  <= 1'b0;
      end else begin
         led_win   <= (state_q == SHOW_WIN)  && (blink_cnt < CNT_HALF);
         led_lose  <= (state_q == SHOW_LOSE) && (blink_cnt < CNT_HALF);
         blink_cnt <= (blink_cnt == CNT_TOP) ? '0 : blink_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_blackjack_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_blackjack_scoreboard
//
// Scoreboard bench: every stimulus pushes its expected outputs with a due
// cycle; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_blackjack_scoreboard;

   localparam int BLINK_DIV = 4;
   localparam int MAX_SCORE = 99;

   localparam int SEL_HP1 = 0, SEL_HP0 = 1, SEL_HD1 = 2, SEL_HD0 = 3;
   localparam int SEL_WIN = 4, SEL_LOSS = 5, SEL_LW = 6, SEL_LL = 7;

   logic       clock;
   logic       reset_n;
   logic [4:0] phand, dhand;
   logic [1:0] result;
   logic       clear_scores;
   logic [6:0] hex_p1, hex_p0, hex_d1, hex_d0;
   logic [6:0] win_count, loss_count;
   logic       led_win, led_lose;

   blackjack_scoreboard #(.BLINK_DIV(BLINK_DIV), .MAX_SCORE(MAX_SCORE)) dut (
      .clock(clock), .reset_n(reset_n), .phand(phand), .dhand(dhand),
      .result(result), .clear_scores(clear_scores),
      .hex_p1(hex_p1), .hex_p0(hex_p0), .hex_d1(hex_d1), .hex_d0(hex_d0),
      .win_count(win_count), .loss_count(loss_count),
      .led_win(led_win), .led_lose(led_lose)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int due;
      int sel;
      int exp_v;
   } sb_item_t;

   sb_item_t sb_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_HP1:  return {25'd0, hex_p1};
         SEL_HP0:  return {25'd0, hex_p0};
         SEL_HD1:  return {25'd0, hex_d1};
         SEL_HD0:  return {25'd0, hex_d0};
         SEL_WIN:  return {25'd0, win_count};
         SEL_LOSS: return {25'd0, loss_count};
         SEL_LW:   return {31'd0, led_win};
         default:  return {31'd0, led_lose};
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         SEL_HP1:  return "hex_p1";
         SEL_HP0:  return "hex_p0";
         SEL_HD1:  return "hex_d1";
         SEL_HD0:  return "hex_d0";
         SEL_WIN:  return "win_count";
         SEL_LOSS: return "loss_count";
         SEL_LW:   return "led_win";
         default:  return "led_lose";
      endcase
   endfunction

   // Reference digit patterns, active low {g,f,e,d,c,b,a}.
   function automatic int seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int tens_of(input int v);
      return (v < 10) ? 7'h7F : seg_of(v / 10);
   endfunction

   task automatic push_exp(input int sel, input int exp_v, input int lat);
      sb_item_t it;
      it.due   = cyc + lat;
      it.sel   = sel;
      it.exp_v = exp_v;
      sb_q.push_back(it);
   endtask

   always @(negedge clock) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].due == cyc) begin
            check_eq($sformatf("%s@%0d", sel_name(sb_q[i].sel), sb_q[i].due),
                     observe(sb_q[i].sel), sb_q[i].exp_v);
            sb_q.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drive_hands(input int p, input int d);
      phand = 5'(p);
      dhand = 5'(d);
      push_exp(SEL_HP1, tens_of(p), 1);
      push_exp(SEL_HP0, seg_of(p % 10), 1);
      push_exp(SEL_HD1, tens_of(d), 1);
      push_exp(SEL_HD0, seg_of(d % 10), 1);
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_hex_p1"}, {25'd0, hex_p1}, 32'h7F);
      check_eq({pfx, "_hex_p0"}, {25'd0, hex_p0}, 32'h7F);
      check_eq({pfx, "_hex_d1"}, {25'd0, hex_d1}, 32'h7F);
      check_eq({pfx, "_hex_d0"}, {25'd0, hex_d0}, 32'h7F);
      check_eq({pfx, "_win"},    {25'd0, win_count}, 32'd0);
      check_eq({pfx, "_loss"},   {25'd0, loss_count}, 32'd0);
      check_eq({pfx, "_led_win"},  {31'd0, led_win}, 32'd0);
      check_eq({pfx, "_led_lose"}, {31'd0, led_lose}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_win;
      int exp_loss;
      int vals[6];
      exp_win  = 0;
      exp_loss = 0;
      vals     = '{9, 10, 19, 20, 29, 30};

      reset_n      = 1'b0;
      phand        = 5'd21;
      dhand        = 5'd17;
      result       = 2'b00;
      clear_scores = 1'b0;
      tick(3);
      check_reset_state("rst");

      // Release reset: hands appear one cycle later.
      reset_n = 1'b1;
      drive_hands(21, 17);
      push_exp(SEL_WIN, 0, 1);
      push_exp(SEL_LOSS, 0, 1);
      tick(1);
      drive_hands(7, 17);
      tick(1);
      drive_hands(31, 17);
      tick(1);
      drive_hands(0, 0);
      tick(1);
      for (int i = 0; i < 6; i++) begin
         drive_hands(vals[i], vals[5 - i]);
         tick(1);
      end
      repeat (10) begin
         drive_hands(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         tick(1);
      end

      // Win held 50 cycles counts once; blink pattern 4 on / 4 off.
      result = 2'b11;
      push_exp(SEL_WIN, exp_win, 1);
      exp_win++;
      push_exp(SEL_WIN, exp_win, 2);
      push_exp(SEL_WIN, exp_win, 50);
      push_exp(SEL_LW, 0, 2);
      for (int k = 2; k <= 14; k++) push_exp(SEL_LL, 0, k);
      for (int k = 3; k <= 14; k++) push_exp(SEL_LW, (((k - 3) % 8) < 4) ? 1 : 0, k);
      tick(50);
      result = 2'b00;
      push_exp(SEL_LW, 0, 2);
      push_exp(SEL_LW, 0, 5);
      push_exp(SEL_WIN, exp_win, 5);
      tick(4);
      result = 2'b01;
      push_exp(SEL_LOSS, exp_loss, 1);
      exp_loss++;
      push_exp(SEL_LOSS, exp_loss, 2);
      push_exp(SEL_WIN, exp_win, 2);
      push_exp(SEL_LL, 1, 3);
      push_exp(SEL_LW, 0, 3);
      tick(6);

      // New win, then a direct flip to lose: no count change.
      result = 2'b00;
      tick(4);
      result = 2'b11;
      exp_win++;
      push_exp(SEL_WIN, exp_win, 2);
      tick(6);
      result = 2'b01;
      push_exp(SEL_WIN, exp_win, 2);
      push_exp(SEL_WIN, exp_win, 6);
      push_exp(SEL_LOSS, exp_loss, 2);
      push_exp(SEL_LOSS, exp_loss, 6);
      push_exp(SEL_LL, 0, 2);
      for (int k = 2; k <= 14; k++) push_exp(SEL_LW, 0, k);
      for (int k = 3; k <= 12; k++) push_exp(SEL_LL, (((k - 3) % 8) < 4) ? 1 : 0, k);
      tick(11);
      // Leave while the LED is lit: it drops when the state returns to WAIT.
      result = 2'b00;
      push_exp(SEL_LL, 0, 2);
      push_exp(SEL_LL, 0, 4);
      tick(4);

      // 100 win rounds, alternating the two playing codes, saturate at 99.
      for (int r = 0; r < 100; r++) begin
         result  = 2'b11;
         exp_win = (exp_win + 1 > MAX_SCORE) ? MAX_SCORE : exp_win + 1;
         push_exp(SEL_WIN, exp_win, 2);
         tick(2);
         result = (r % 2 == 1) ? 2'b10 : 2'b00;
         tick(2);
      end
      push_exp(SEL_WIN, MAX_SCORE, 1);
      push_exp(SEL_LOSS, exp_loss, 1);

      // Clear coinciding with a loss event: clear wins, state still moves.
      result = 2'b01;
      tick(1);
      clear_scores = 1'b1;
      push_exp(SEL_WIN, 0, 1);
      push_exp(SEL_LOSS, 0, 1);
      push_exp(SEL_LOSS, 0, 5);
      push_exp(SEL_LL, 1, 2);
      push_exp(SEL_LL, 1, 3);
      push_exp(SEL_LL, 0, 6);
      tick(1);
      clear_scores = 1'b0;
      tick(8);

      // Asynchronous reset mid-cycle with a win already presented.
      result = 2'b11;
      tick(1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_state("arst");
      tick(2);
      reset_n = 1'b1;
      drive_hands(25, 4);
      push_exp(SEL_WIN, 0, 1);
      push_exp(SEL_WIN, 1, 2);
      push_exp(SEL_WIN, 1, 10);
      push_exp(SEL_LOSS, 0, 2);
      push_exp(SEL_LW, 0, 2);
      push_exp(SEL_LW, 1, 3);
      tick(12);

      tick(2);
      check_eq("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
